// File: rtl/ram_image_loader.sv
// Image RAM loader: writes a byte stream into the image RAM from address 0 and
// hands the RAM port to the display fetcher on every cycle that carries no write.
module ram_image_loader #(
    parameter int unsigned AddressWidth = 14,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned ImagePixels  = 2 ** AddressWidth
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AddressWidth-1:0] disp_addr,
    output logic                    disp_stall,
    output logic                    ram_rw,
    output logic [AddressWidth-1:0] ram_addr,
    output logic [DataWidth-1:0]    ram_data,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             checksum
);

    localparam int unsigned CountWidth = AddressWidth + 1;
    localparam int unsigned SumWidth   = 16;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(ImagePixels - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [AddressWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0]    wr_data_q, wr_data_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic [SumWidth-1:0]     checksum_q, checksum_d;
    logic                    xfer;

    // State and write-path registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
        end
    end

    // Next-state and write-path logic.
    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        xfer       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    checksum_d = '0;
                end
            end
            LOAD: begin
                xfer = in_valid;
                if (xfer) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = count_q[AddressWidth-1:0];
                    wr_data_d  = in_data;
                    count_d    = count_q + CountWidth'(1);
                    checksum_d = checksum_q + SumWidth'(in_data);
                    if (count_q == LastCount) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pending write owns the RAM port; otherwise the display address passes through.
    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign ram_rw     = ~wr_en_q;
    assign ram_addr   = wr_en_q ? wr_addr_q : disp_addr;
    assign ram_data   = wr_data_q;
    assign disp_stall = wr_en_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_ram_image_loader.sv
// Bench for ram_image_loader: two instances (16- and 4-byte images) driving RAM models,
// checked cycle by cycle against a byte-count/scoreboard model of a load.
module tb_ram_image_loader;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned NI    = 2;
    localparam int unsigned Depth = 1 << AW;
    localparam logic [DW-1:0] Sentinel = 8'hEE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn      [NI];
    logic          start     [NI];
    logic          in_valid  [NI];
    logic [DW-1:0] in_data   [NI];
    logic [AW-1:0] disp_addr [NI];
    logic          in_ready  [NI];
    logic          disp_stall[NI];
    logic          ram_rw    [NI];
    logic [AW-1:0] ram_addr  [NI];
    logic [DW-1:0] ram_data  [NI];
    logic          busy      [NI];
    logic          done      [NI];
    logic [15:0]   checksum  [NI];

    ram_image_loader #(.AddressWidth(AW), .DataWidth(DW), .ImagePixels(16)) u_dut16 (
        .clk(clk), .rstn(rstn[0]), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .disp_addr(disp_addr[0]),
        .disp_stall(disp_stall[0]), .ram_rw(ram_rw[0]), .ram_addr(ram_addr[0]),
        .ram_data(ram_data[0]), .busy(busy[0]), .done(done[0]), .checksum(checksum[0])
    );

    ram_image_loader #(.AddressWidth(AW), .DataWidth(DW), .ImagePixels(4)) u_dut4 (
        .clk(clk), .rstn(rstn[1]), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .disp_addr(disp_addr[1]),
        .disp_stall(disp_stall[1]), .ram_rw(ram_rw[1]), .ram_addr(ram_addr[1]),
        .ram_data(ram_data[1]), .busy(busy[1]), .done(done[1]), .checksum(checksum[1])
    );

    // Image RAM models: write when rw=0, registered read otherwise (data_out holds on writes).
    logic [DW-1:0] mem [NI][Depth];
    logic [DW-1:0] dout[NI];
    logic          mem_clr;

    always @(posedge clk) begin
        for (int u = 0; u < NI; u++) begin
            if (mem_clr) begin
                for (int a = 0; a < Depth; a++) mem[u][a] <= Sentinel;
            end else if (ram_rw[u] === 1'b0) begin
                mem[u][ram_addr[u]] <= ram_data[u];
            end else begin
                dout[u] <= mem[u][ram_addr[u]];
            end
        end
    end

    // Reference model: bytes still owed by the current load, pending write, running sum.
    int            m_left [NI];
    int            m_next [NI];
    bit            m_done [NI];
    bit            m_pend [NI];
    logic [AW-1:0] m_pa   [NI];
    logic [DW-1:0] m_pd   [NI];
    logic [15:0]   m_sum  [NI];
    logic [DW-1:0] img    [NI][Depth];
    bit            m_known;
    bit            hold_disp;
    bit            chk_dout;
    int            done_cnt [NI];
    int            wr_cnt   [NI];
    int            vec;
    int            errs;

    function automatic int npix(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    task automatic chk(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL u%0d %s: observed %0h expected %0h", u, tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int u);
        chk(u, "in_ready",   32'(in_ready[u]),   32'(m_left[u] > 0));
        chk(u, "busy",       32'(busy[u]),       32'(m_left[u] > 0));
        chk(u, "done",       32'(done[u]),       32'(m_done[u]));
        chk(u, "ram_rw",     32'(ram_rw[u]),     32'(!m_pend[u]));
        chk(u, "disp_stall", 32'(disp_stall[u]), 32'(m_pend[u]));
        chk(u, "ram_addr",   32'(ram_addr[u]),   32'(m_pend[u] ? m_pa[u] : disp_addr[u]));
        if (m_pend[u]) chk(u, "ram_data", 32'(ram_data[u]), 32'(m_pd[u]));
        chk(u, "checksum",   32'(checksum[u]),   32'(m_sum[u]));
        if (done[u] === 1'b1) done_cnt[u]++;
        if (ram_rw[u] === 1'b0) wr_cnt[u]++;
    endtask

    task automatic update(input int u);
        bit idle;
        bit acc;
        if (!rstn[u]) begin
            m_left[u] = 0; m_next[u] = 0; m_done[u] = 0; m_pend[u] = 0; m_sum[u] = '0;
        end else begin
            idle = (m_left[u] == 0) && !m_done[u];
            acc  = (m_left[u] > 0) && in_valid[u];
            m_done[u] = acc && (m_left[u] == 1);
            m_pend[u] = acc;
            if (acc) begin
                m_pa[u] = AW'(m_next[u]);
                m_pd[u] = in_data[u];
                img[u][m_next[u]] = in_data[u];
                m_sum[u] = m_sum[u] + 16'(in_data[u]);
                m_next[u]++;
                m_left[u]--;
            end
            if (idle && start[u]) begin
                m_left[u] = npix(u);
                m_next[u] = 0;
                m_sum[u]  = '0;
            end
        end
    endtask

    // One clock: check pre-edge outputs, take the edge, advance the model.
    task automatic step();
        int a0;
        for (int u = 0; u < NI; u++) if (!hold_disp) disp_addr[u] = AW'($urandom);
        #1;
        if (m_known) for (int u = 0; u < NI; u++) check_outputs(u);
        a0 = int'(disp_addr[0]);
        @(posedge clk);
        for (int u = 0; u < NI; u++) update(u);
        m_known = 1'b1;
        #1;
        if (chk_dout) chk(0, "dout", 32'(dout[0]), 32'(img[0][a0]));
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int u = 0; u < NI; u++) begin
            rstn[u] = 1'b1; start[u] = 1'b0; in_valid[u] = 1'b0; in_data[u] = DW'($urandom);
        end
    endtask

    task automatic cmp_mem(input int u);
        for (int a = 0; a < Depth; a++) chk(u, "mem", 32'(mem[u][a]), 32'(img[u][a]));
    endtask

    initial begin
        vec = 0; errs = 0; m_known = 1'b0; hold_disp = 1'b0; chk_dout = 1'b0; mem_clr = 1'b1;
        for (int u = 0; u < NI; u++) begin
            for (int a = 0; a < Depth; a++) img[u][a] = Sentinel;
            m_left[u] = 0; m_next[u] = 0; m_done[u] = 0; m_pend[u] = 0;
            m_pa[u] = '0; m_pd[u] = '0; m_sum[u] = '0; done_cnt[u] = 0; wr_cnt[u] = 0;
            disp_addr[u] = '0;
        end

        // Reset held two cycles with start and in_valid asserted
        for (int k = 0; k < 2; k++) begin
            idle_all();
            for (int u = 0; u < NI; u++) begin
                rstn[u] = 1'b0; start[u] = 1'b1; in_valid[u] = 1'b1;
            end
            step();
        end
        mem_clr = 1'b0;
        idle_all(); step();
        for (int u = 0; u < NI; u++) chk(u, "rst_checksum", 32'(checksum[u]), 32'h0);

        // Full 16-byte back-to-back load of 0x00..0x0F
        done_cnt[0] = 0;
        idle_all(); start[0] = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            idle_all(); in_valid[0] = 1'b1; in_data[0] = DW'(i); step();
        end
        for (int k = 0; k < 3; k++) begin idle_all(); step(); end
        chk(0, "t2_checksum", 32'(checksum[0]), 32'h0078);
        chk(0, "t2_done_cnt", 32'(done_cnt[0]), 32'd1);
        cmp_mem(0);

        // Gapped 4-byte stream, in_valid toggling; extra valids after the load are ignored
        wr_cnt[1] = 0;
        idle_all(); start[1] = 1'b1; step();
        for (int k = 0; k < 12; k++) begin
            idle_all();
            if (k % 2 == 0) begin
                in_valid[1] = 1'b1;
                in_data[1]  = ((k / 2) % 2 == 1) ? 8'h5A : 8'hA5;
            end
            step();
        end
        chk(1, "t3_writes", 32'(wr_cnt[1]), 32'd4);
        chk(1, "t3_checksum", 32'(checksum[1]), 32'h01FE);
        cmp_mem(1);

        // Display passthrough sweep in idle
        hold_disp = 1'b1; chk_dout = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idle_all(); disp_addr[0] = AW'(i); step();
        end
        hold_disp = 1'b0; chk_dout = 1'b0;

        // Reset during a load, with start and a byte offered on the reset edge
        idle_all(); start[0] = 1'b1; step();
        for (int i = 0; i < 7; i++) begin
            idle_all(); in_valid[0] = 1'b1; in_data[0] = DW'($urandom); step();
        end
        idle_all(); rstn[0] = 1'b0; start[0] = 1'b1; in_valid[0] = 1'b1; step();
        for (int k = 0; k < 3; k++) begin idle_all(); step(); end
        cmp_mem(0);
        idle_all(); start[0] = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            idle_all(); in_valid[0] = 1'b1; in_data[0] = DW'($urandom); step();
        end
        for (int k = 0; k < 3; k++) begin idle_all(); step(); end
        cmp_mem(0);

        // start pulses during LOAD and in the DONE cycle are ignored
        idle_all(); start[0] = 1'b1; step();
        for (int k = 0; k < 80 && m_left[0] > 0; k++) begin
            idle_all(); in_valid[0] = 1'($urandom); in_data[0] = 8'hFF; start[0] = 1'($urandom);
            step();
        end
        idle_all(); start[0] = 1'b1; step();
        chk(0, "t6_checksum", 32'(checksum[0]), 32'h0FF0);

        // start right after DONE begins a randomized gapped load
        idle_all(); start[0] = 1'b1; step();
        for (int k = 0; k < 80 && m_left[0] > 0; k++) begin
            idle_all(); in_valid[0] = 1'($urandom); in_data[0] = DW'($urandom); step();
        end
        for (int k = 0; k < 3; k++) begin idle_all(); step(); end
        cmp_mem(0);
        cmp_mem(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
